// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bundle between the interconnect and one memory target.
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  hselx;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic                  hready;
    logic [31:0]           hwdata;
    logic                  hreadyout;
    logic [31:0]           hrdata;
    logic [1:0]            hresp;

    modport master (
        output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM target with programmable wait states, byte-lane writes and
// two-cycle ERROR responses for misaligned, oversized or out-of-range transfers.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH       = 32,
    parameter int ADDR_OFFSET_BITS = 30,
    parameter int MEM_DEPTH_WORDS  = 1024,
    parameter int WAIT_STATES      = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int         IDX_W       = $clog2(MEM_DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD_C = 4'(WAIT_STATES - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_ERROR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t           state_r;
    logic [3:0]       wait_cnt_r;
    logic             valid_r;
    logic             wr_r;
    logic [IDX_W-1:0] idx_r;
    logic [3:0]       be_r;
    logic             hreadyout_r;
    logic [1:0]       hresp_r;
    logic [31:0]      hrdata_r;
    logic [31:0]      mem_r [MEM_DEPTH_WORDS];

    logic             accept_s;
    logic             err_s;
    logic             wr_commit_s;
    logic             fwd_hit_s;
    logic [IDX_W-1:0] acc_idx_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      fwd_rdata_s;
    logic             unused_s;

    function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo, input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            3'b000:  mask = 4'b0001 << addr_lo;
            3'b001:  mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic xfer_error(input logic [ADDR_OFFSET_BITS-1:0] offset,
                                        input logic [2:0] size);
        logic bad;
        case (size)
            3'b000:  bad = 1'b0;
            3'b001:  bad = offset[0];
            3'b010:  bad = (offset[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || ((offset >> (IDX_W + 2)) != {ADDR_OFFSET_BITS{1'b0}});
    endfunction

    // Upper select bits and sideband controls carry no meaning inside the target.
    assign unused_s = ^{bus.hburst, bus.hprot, bus.hmastlock,
                        bus.haddr[ADDR_WIDTH-1:ADDR_OFFSET_BITS]};

    // Address-phase decode plus forwarding of a committing write into a chained read.
    always_comb begin
        accept_s    = 1'b0;
        fwd_rdata_s = 32'h0;
        if ((state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2)) begin
            accept_s = bus.hselx && bus.hready && bus.htrans[1];
        end else begin
            accept_s = 1'b0;
        end
        err_s       = xfer_error(bus.haddr[ADDR_OFFSET_BITS-1:0], bus.hsize);
        acc_idx_s   = bus.haddr[IDX_W+1:2];
        wr_commit_s = (state_r == ST_DATA) && valid_r && wr_r;
        rd_word_s   = mem_r[acc_idx_s];
        fwd_hit_s   = wr_commit_s && (idx_r == acc_idx_s);
        for (int i = 0; i < 4; i++) begin
            fwd_rdata_s[8*i +: 8] = (fwd_hit_s && be_r[i]) ? bus.hwdata[8*i +: 8]
                                                           : rd_word_s[8*i +: 8];
        end
    end

    // Transfer FSM; all bus outputs are registered from the next state.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            valid_r     <= 1'b0;
            wr_r        <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            be_r        <= 4'b0000;
            hreadyout_r <= 1'b1;
            hresp_r     <= RESP_OKAY;
            hrdata_r    <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept_s) begin
                        valid_r <= 1'b1;
                        wr_r    <= bus.hwrite;
                        idx_r   <= acc_idx_s;
                        be_r    <= lane_mask(bus.haddr[1:0], bus.hsize);
                        if (err_s) begin
                            state_r     <= ST_ERR1;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= RESP_ERROR;
                            hrdata_r    <= 32'h0;
                        end else if (WAIT_STATES > 0) begin
                            state_r     <= ST_WAIT;
                            wait_cnt_r  <= WAIT_LOAD_C;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= RESP_OKAY;
                            hrdata_r    <= 32'h0;
                        end else begin
                            state_r     <= ST_DATA;
                            hreadyout_r <= 1'b1;
                            hresp_r     <= RESP_OKAY;
                            hrdata_r    <= bus.hwrite ? 32'h0 : fwd_rdata_s;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        valid_r     <= 1'b0;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= RESP_OKAY;
                        hrdata_r    <= 32'h0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r     <= ST_DATA;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= RESP_OKAY;
                        hrdata_r    <= wr_r ? 32'h0 : mem_r[idx_r];
                    end else begin
                        wait_cnt_r  <= wait_cnt_r - 4'd1;
                        hreadyout_r <= 1'b0;
                        hresp_r     <= RESP_OKAY;
                        hrdata_r    <= 32'h0;
                    end
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= RESP_ERROR;
                    hrdata_r    <= 32'h0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    valid_r     <= 1'b0;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= RESP_OKAY;
                    hrdata_r    <= 32'h0;
                end
            endcase
        end
    end

    // Byte-lane commit at the end of a write data phase; the array has no reset.
    always_ff @(posedge hclk) begin
        if (!hreset && wr_commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = hreadyout_r;
    assign bus.hresp     = hresp_r;
    assign bus.hrdata    = hrdata_r;
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Per-slave AHB-Lite memory target that sits directly downstream of the AHB interconnect.
- Connects to one slave-side port and consumes hselx/haddr/htrans/hwrite/hsize/hwdata.
- Returns hreadyout/hrdata/hresp to the interconnect, which routes them back to the owning master.
- Supports programmable wait states, byte/halfword/word writes and two-cycle ERROR responses, so interconnect stalls and error paths can be exercised end to end.

Parameters:
- ADDR_WIDTH, 32, width of haddr.
- ADDR_OFFSET_BITS, 30, low haddr bits that form the in-slave offset; the upper bits are interconnect slave select and are ignored here.
- MEM_DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, at least 4.
- WAIT_STATES, 0, data-phase wait cycles inserted per OKAY transfer (0..15).

Ports:
- hclk  input  1  bus clock; all state updates on its rising edge.
- hreset  input  1  synchronous active-high reset.
- hselx  input  1  slave select from interconnect.
- haddr  input  ADDR_WIDTH  byte address.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  input  1  1 = write.
- hsize  input  3  000 byte, 001 halfword, 010 word; any other value is an error.
- hburst  input  3  accepted, no effect.
- hprot  input  4  accepted, no effect.
- hmastlock  input  1  accepted, no effect.
- hready  input  1  bus-level ready; an address phase is sampled only when high.
- hwdata  input  32  write data, valid in the data phase.
- hreadyout  output  1  slave ready.
- hrdata  output  32  read data.
- hresp  output  2  00 OKAY, 01 ERROR.

Behaviour:
- Clock and reset: one clock (hclk); reset (hreset) is synchronous and active-high.
- Reset values: state IDLE, hreadyout=1, hresp=00, hrdata=0, wait counter 0, latched phase invalid. Memory array is not reset.
- Transfer accept: hselx && hready && htrans[1] at a rising edge. The block latches addr, size, write and the error flag.
  - BUSY or IDLE with hselx: no access; next cycle hreadyout=1, hresp=00.
- Error detection, evaluated at accept:
  - hsize > 010.
  - hsize=001 with haddr[0]=1.
  - hsize=010 with haddr[1:0]!=0.
  - haddr[ADDR_OFFSET_BITS-1 : log2(MEM_DEPTH_WORDS)+2] non-zero (out of range).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on accept go to ERR1 if error; else WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1); else DATA.
  - WAIT: hreadyout=0, hresp=00; counter decrements; go to DATA when counter=0.
  - DATA: hreadyout=1, hresp=00.
    - Read: hrdata = mem[latched word index], full 32 bits, no lane masking.
    - Write: at the end-of-cycle edge, write hwdata into enabled byte lanes, little-endian. Byte: lane = addr[1:0]. Halfword: lanes {addr[1],0} and {addr[1],1}. Word: all 4 lanes.
    - A new accept in the same cycle chains directly to ERR1/WAIT/DATA (pipelined back-to-back); otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=01. No memory access. Next state ERR2.
  - ERR2: hreadyout=1, hresp=01. An accept here is honoured exactly as in DATA.
- hrdata is 0 in every cycle that is not a read DATA cycle.
- Write data phase followed immediately by a read data phase to the same word: the read returns the newly written bytes (write commits on the edge that starts the read data phase).
- Accepts during WAIT or ERR1 cannot occur (hreadyout=0 forces hready=0). If hready is seen high there anyway, the block ignores it.
- Reset asserted in any state: next cycle equals the reset values; any pending write is dropped.
- Latency for a read: (WAIT_STATES + 1) cycles from address accept to data.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data-phase hrdata=0xDEADBEEF, hreadyout=1 throughout, hresp=00.
- Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, then word read 0x20 -> 0x44332211. Halfword 0xABCD to 0x22, then read -> 0xABCD2211.
- WAIT_STATES=3: read 0x40 -> hreadyout low exactly 3 cycles, then high with correct data. Write under the same setting -> memory updated only after the 4th data-phase cycle.
- Errors:
  - Word access to 0x42 -> cycle1 hreadyout=0/hresp=01, cycle2 hreadyout=1/hresp=01; a subsequent read of 0x40 shows unchanged content.
  - hsize=011 -> same two-cycle error.
  - Address 1<<(log2(MEM_DEPTH_WORDS)+2) -> same two-cycle error.
- BUSY with hselx=1, and NONSEQ with hready=0 -> no access, hreadyout=1, hresp=00, memory unchanged.
- Reset in the middle of WAIT during a write -> next cycle hreadyout=1, hresp=00, hrdata=0; the target word retains its previous value.
